// File: rtl/axi_pkg.sv
// Shared AXI encodings, FSM state type and address-advance helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_MEM,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_WR_RESP
  } state_t;

  // FIXED bursts hit the same address every beat; every other encoding increments.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    if (burst == BURST_FIXED) return addr;
    return addr + (32'd1 << size);
  endfunction

endpackage

// File: rtl/axi_sram_slave_if.sv
// AXI3 read/write channel bundle between a master and the SRAM responder.
// Latency: n/a (wires only).
// Backpressure: valid/ready on each of AR, R, AW, W, B.
interface axi_sram_slave_if;

  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;

  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid;
  logic        awready;

  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;

  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready,
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready,
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

endinterface

// File: rtl/sram_sp.sv
// Single-port WORDS x 32 memory with per-byte write enables.
// Latency: 1-cycle synchronous read; write commits on the clock edge.
// Backpressure: none; rdata holds its value until the next read enable.
module sram_sp #(
  parameter int WORDS = 1024,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          re,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Contents survive reset, so the array and read register are deliberately unreset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 responder serialising reads and writes onto one single-port SRAM.
// Latency: AR->first R 2 cycles, 2 cycles per R beat; AW->wready 1 cycle, last W->B 1 cycle.
// Backpressure: R/B held until rready/bready; AR/AW/W stalled while another burst is active.
module axi_sram_slave
  import axi_pkg::*;
#(
  parameter int          MEM_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input logic             aclk,
  input logic             areset,
  axi_sram_slave_if.slave bus
);

  localparam int          AW   = $clog2(MEM_WORDS);
  localparam logic [31:0] SPAN = 32'(MEM_WORDS * 4);

  state_t      state_q, state_d;
  logic        pri_wr_q;   // 1: write side wins the next tie
  logic [3:0]  id_q;
  logic [31:0] addr_q;
  logic [7:0]  len_q;
  logic [7:0]  cnt_q;
  logic [2:0]  size_q;
  logic [1:0]  burst_q;
  logic        err_q;

  logic [31:0]   off;
  logic          in_range;
  logic [AW-1:0] widx;
  logic          last_beat;
  logic          rd_grant;
  logic          wr_grant;
  logic          mem_re;
  logic [3:0]    mem_we;
  logic [31:0]   mem_rdata;
  logic          unused_w;

  assign off       = addr_q - BASE_ADDR;
  assign in_range  = off < SPAN;
  assign widx      = off[AW+1:2];
  assign last_beat = (cnt_q == len_q);
  assign unused_w  = ^{bus.wid, bus.wlast};

  // Round-robin tie break; readies are forced low while reset is asserted.
  assign rd_grant = (state_q == ST_IDLE) && !areset && bus.arvalid &&
                    (!bus.awvalid || !pri_wr_q);
  assign wr_grant = (state_q == ST_IDLE) && !areset && bus.awvalid &&
                    (!bus.arvalid || pri_wr_q);
  assign bus.arready = rd_grant;
  assign bus.awready = wr_grant;

  // State register; reset abandons any burst in flight.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state and channel outputs decoded from the current state.
  always_comb begin
    state_d     = state_q;
    bus.rvalid  = 1'b0;
    bus.wready  = 1'b0;
    bus.bvalid  = 1'b0;
    mem_re      = 1'b0;
    mem_we      = 4'b0000;
    case (state_q)
      ST_IDLE: begin
        if (rd_grant)      state_d = ST_RD_MEM;
        else if (wr_grant) state_d = ST_WR_DATA;
      end
      ST_RD_MEM: begin
        mem_re  = in_range;
        state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        bus.rvalid = 1'b1;
        if (bus.rready) state_d = last_beat ? ST_IDLE : ST_RD_MEM;
      end
      ST_WR_DATA: begin
        bus.wready = 1'b1;
        if (bus.wvalid) begin
          if (in_range) mem_we = bus.wstrb;
          if (last_beat) state_d = ST_WR_RESP;
        end
      end
      ST_WR_RESP: begin
        bus.bvalid = 1'b1;
        if (bus.bready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Burst context: latched on address acceptance, advanced per data beat.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      pri_wr_q <= 1'b0;
      id_q     <= 4'd0;
      addr_q   <= 32'd0;
      len_q    <= 8'd0;
      cnt_q    <= 8'd0;
      size_q   <= 3'd0;
      burst_q  <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rd_grant) begin
            id_q     <= bus.arid;
            addr_q   <= bus.araddr;
            len_q    <= bus.arlen;
            size_q   <= bus.arsize;
            burst_q  <= bus.arburst;
            cnt_q    <= 8'd0;
            pri_wr_q <= 1'b1;
          end else if (wr_grant) begin
            id_q     <= bus.awid;
            addr_q   <= bus.awaddr;
            len_q    <= bus.awlen;
            size_q   <= bus.awsize;
            burst_q  <= bus.awburst;
            cnt_q    <= 8'd0;
            pri_wr_q <= 1'b0;
          end
        end
        ST_RD_DATA: begin
          if (bus.rready && !last_beat) begin
            addr_q <= next_addr(addr_q, size_q, burst_q);
            cnt_q  <= cnt_q + 8'd1;
          end
        end
        ST_WR_DATA: begin
          if (bus.wvalid) begin
            addr_q <= next_addr(addr_q, size_q, burst_q);
            cnt_q  <= cnt_q + 8'd1;
            if (!in_range) err_q <= 1'b1;
          end
        end
        ST_WR_RESP: begin
          if (bus.bready) err_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.rid   = id_q;
  assign bus.rlast = bus.rvalid && last_beat;
  assign bus.rdata = (bus.rvalid && in_range) ? mem_rdata : 32'd0;
  assign bus.rresp = (bus.rvalid && !in_range) ? RESP_DECERR : RESP_OKAY;
  assign bus.bid   = id_q;
  assign bus.bresp = (bus.bvalid && err_q) ? RESP_DECERR : RESP_OKAY;

  sram_sp #(
    .WORDS (MEM_WORDS)
  ) u_sram (
    .clk   (aclk),
    .re    (mem_re),
    .we    (mem_we),
    .addr  (widx),
    .wdata (bus.wdata),
    .rdata (mem_rdata)
  );

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3 slave (responder) that backs a 32-bit word-addressed on-chip memory and answers read and write transactions issued by the CPU's AXI bridge. It lets the core's AXI master be simulated and tested without the external SoC crossbar. Transactions are serialised through one state machine sharing a single-port memory. Read/write arbitration is round-robin, and out-of-range accesses return DECERR.

## Interface
- MEM_WORDS, 1024: memory depth in 32-bit words; power of two, ≥ 16
- BASE_ADDR, 32'h0000_0000: byte address of word 0; word-aligned
- aclk  in  1  clock, all logic rising-edge
- areset  in  1  reset, asynchronous, active-high
- arid  in  4  read ID
- araddr  in  32  read start byte address
- arlen  in  8  beats-1; only 0..15 legal (AXI3)
- arsize  in  3  bytes per beat = 1<<arsize; ≤ 2
- arburst  in  2  00 FIXED, all others INCR
- arvalid  in  1  / arready  out  1  AR handshake
- rid  out  4, rdata  out  32, rresp  out  2, rlast  out  1, rvalid  out  1 / rready  in  1  R channel
- awid  in  4, awaddr  in  32, awlen  in  8, awsize  in  3, awburst  in  2: same encodings as AR
- awvalid  in  1  / awready  out  1  AW handshake
- wid  in  4  ignored; wdata  in  32; wstrb  in  4; wlast  in  1  ignored for termination
- wvalid  in  1  / wready  out  1  W handshake
- bid  out  4, bresp  out  2, bvalid  out  1 / bready  in  1  B channel

## Operation
- States: IDLE, RD_MEM, RD_DATA, WR_DATA, WR_RESP. Reset → IDLE, pri = read.
- IDLE grant: only arvalid → arready=1; only awvalid → awready=1; both → side selected by pri. arready and awready are never both 1. Both are 0 outside IDLE and while areset is high.
- Accepted read → latch id/addr/len/size/burst, beat counter := 0, pri := write, go to RD_MEM. Accepted write → latch the same fields, pri := read, go to WR_DATA.
- RD_MEM: issue memory read of the current word → RD_DATA.
- RD_DATA: rvalid=1. rid = latched id; rlast = (counter==len); rdata = memory output, or 0 if out of range; rresp = 2'b00 OKAY, or 2'b11 DECERR if out of range. Output is held stable until rready. On handshake: if rlast → IDLE, else advance address and go to RD_MEM.
- WR_DATA: wready=1. On each W handshake, write the enabled byte lanes of wdata per wstrb (only if in range), then advance the address. When counter==len → WR_RESP. Any beat out of range sets a sticky err flag.
- WR_RESP: bvalid=1, bid = latched id, bresp = err ? 2'b11 : 2'b00. On bready → IDLE and clear err.
- Address advance: FIXED → unchanged; INCR → addr + (1<<size), 32-bit wrap. Word index = (addr−BASE_ADDR)[log2(MEM_WORDS)+1:2]. In range iff addr−BASE_ADDR (unsigned) < MEM_WORDS*4.
- Sub-word reads return the full word; the master selects the lane.
- W beats presented before their AW are stalled (wready=0 outside WR_DATA).

## Timing
- Reset values: arready, awready, rvalid, wready, bvalid = 0; rid, rdata, rresp, rlast, bid, bresp = 0.
- Read: AR handshake at cycle T → rvalid at T+2. Subsequent beats arrive 2 cycles after the previous R handshake, so each beat takes at least 2 cycles.
- Write: AW handshake at T → wready from T+1. Memory write commits at the W handshake edge. bvalid follows 1 cycle after the last W handshake.
- A read at T+1 of a word written at T returns the new data.
- areset mid-transaction: the FSM returns to IDLE and all valid/ready signals drop immediately (asynchronous). Memory contents are retained; the partial burst is abandoned.

## Structure
- Shared package axi_pkg: RESP_OKAY=2'b00, RESP_DECERR=2'b11, BURST_FIXED=2'b00, BURST_INCR=2'b01, and the state encoding.
- Sub-module sram_sp (MEM_WORDS×32, 1-cycle synchronous read, per-byte write enable). Instantiated once.

## Test plan
- Single read of araddr=0x10, arid=3, after preloading word 4 = 0xDEADBEEF → rvalid at T+2, rdata=0xDEADBEEF, rid=3, rresp=0, rlast=1.
- Write of 0x11223344 to 0x20 with wstrb=4'b0101, awlen=0, over old 0xFFFFFFFF → bresp=0, bid echoed; readback gives 0xFF22FF44.
- INCR read burst arlen=3 from 0x0 with rready toggling every cycle → 4 beats of words 0..3, rlast only on beat 4, data stable while stalled.
- arvalid and awvalid asserted together three times from reset → grant order is read, write, read; never both readies high in one cycle.
- Read from BASE_ADDR+MEM_WORDS*4 → rresp=2'b11, rdata=0. Write burst awlen=1 straddling the top boundary → first word written, bresp=2'b11.
- areset pulsed during RD_DATA of a 4-beat burst → rvalid=0 immediately; the next read of the same address completes normally.
